deit_tile_sequencer: RTL and testbench

DEIT_TILE_SEQUENCER -- requirements
Module: deit_tile_sequencer

---
 rtl/deit_pkg.sv | 15 +
 rtl/deit_tile_sequencer.sv | 157 +++++++++++++++
 tb/tb_deit_tile_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/deit_pkg.sv
// deit_pkg: shared state encoding and default count widths for the DeiT tile sequencer
package deit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IN,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DEF_N_TILES_W = 8;
    localparam int DEF_K_TILES_W = 8;

endpackage

// File: rtl/deit_tile_sequencer.sv
// deit_tile_sequencer: walks n (output tiles) x k (reduction tiles), issuing DMA requests and compute starts.
// Optional busy-cycle counter enabled by defining TILE_SEQ_PERF_CNT_EN.
module deit_tile_sequencer
    import deit_pkg::*;
#(
    parameter int N_TILES_W = DEF_N_TILES_W,
    parameter int K_TILES_W = DEF_K_TILES_W,
    parameter int PERF_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [N_TILES_W-1:0] cfg_n_tiles,
    input  logic [K_TILES_W-1:0] cfg_k_tiles,
    output logic                 dma_in_req,
    output logic                 dma_wt_req,
    input  logic                 dma_ack,
    output logic [K_TILES_W-1:0] dma_k_idx,
    output logic [N_TILES_W-1:0] dma_n_idx,
    output logic                 core_start,
    output logic                 core_acc_mode,
    output logic                 core_out_en,
    input  logic                 core_done,
    input  logic                 out_done,
    output logic                 seq_busy,
    output logic                 seq_done,
    output logic                 seq_err,
    output logic [PERF_W-1:0]    perf_cycles
);

    localparam logic [K_TILES_W-1:0] K_ONE = 1;
    localparam logic [N_TILES_W-1:0] N_ONE = 1;

    state_t                 r_state;
    logic [K_TILES_W-1:0]   r_k;
    logic [K_TILES_W-1:0]   r_kt;
    logic [N_TILES_W-1:0]   r_n;
    logic [N_TILES_W-1:0]   r_nt;
    logic                   r_wt_req;
    logic                   r_start;
    logic                   r_err;

    logic w_k_last;
    logic w_n_last;
    logic w_tile;
    logic w_cfg_zero;
    logic w_bad_ack;
    logic w_bad_out;
    logic w_early;

    assign w_k_last   = r_k == r_kt - K_ONE;
    assign w_n_last   = r_n == r_nt - N_ONE;
    assign w_tile     = r_state == S_LOAD_IN || r_state == S_COMPUTE;
    assign w_cfg_zero = cfg_n_tiles == '0 || cfg_k_tiles == '0;
    assign w_bad_ack  = dma_ack && !(r_state == S_LOAD_IN || (r_state == S_COMPUTE && r_wt_req));
    assign w_bad_out  = out_done && r_state != S_DRAIN;
    assign w_early    = r_state == S_COMPUTE && core_done && r_wt_req && !dma_ack;

    assign dma_in_req    = r_state == S_LOAD_IN;
    assign dma_wt_req    = r_wt_req;
    assign dma_k_idx     = r_k;
    assign dma_n_idx     = r_n;
    assign core_start    = r_start;
    assign core_acc_mode = w_tile && r_k != '0;
    assign core_out_en   = w_tile && w_k_last;
    assign seq_busy      = r_state != S_IDLE;
    assign seq_done      = r_state == S_DONE;
    assign seq_err       = r_err;

    // Sequencer FSM: abort wins over every state, stray handshakes only flag the sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_kt     <= '0;
            r_n      <= '0;
            r_nt     <= '0;
            r_wt_req <= 1'b0;
            r_start  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_err   <= r_err | w_bad_ack | w_bad_out | w_early;
            if (cfg_abort && r_state != S_IDLE) begin
                r_state  <= S_IDLE;
                r_wt_req <= 1'b0;
                r_k      <= '0;
                r_n      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cfg_start) begin
                            r_kt    <= cfg_k_tiles;
                            r_nt    <= cfg_n_tiles;
                            r_k     <= '0;
                            r_n     <= '0;
                            r_err   <= w_cfg_zero;
                            r_state <= w_cfg_zero ? S_DONE : S_LOAD_IN;
                        end
                    end
                    S_LOAD_IN: begin
                        if (dma_ack) begin
                            r_state  <= S_COMPUTE;
                            r_start  <= 1'b1;
                            r_wt_req <= 1'b1;
                        end
                    end
                    S_COMPUTE: begin
                        if (dma_ack || core_done)
                            r_wt_req <= 1'b0;
                        if (core_done) begin
                            r_state <= w_k_last ? S_DRAIN : S_LOAD_IN;
                            if (!w_k_last)
                                r_k <= r_k + K_ONE;
                        end
                    end
                    S_DRAIN: begin
                        if (out_done) begin
                            r_state <= w_n_last ? S_DONE : S_LOAD_IN;
                            if (!w_n_last) begin
                                r_n <= r_n + N_ONE;
                                r_k <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                        r_n     <= '0;
                    end
                endcase
            end
        end
    end

`ifdef TILE_SEQ_PERF_CNT_EN
    localparam logic [PERF_W-1:0] P_ONE = 1;

    logic [PERF_W-1:0] r_perf;

    // Busy-cycle counter: cleared on run start, saturating
    always_ff @(posedge clk) begin
        if (rst)
            r_perf <= '0;
        else if (r_state == S_IDLE && cfg_start)
            r_perf <= '0;
        else if (r_state != S_IDLE && r_perf != '1)
            r_perf <= r_perf + P_ONE;
    end

    assign perf_cycles = r_perf;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_deit_tile_sequencer.sv
// tb_deit_tile_sequencer: directed scoreboard bench for deit_tile_sequencer
module tb_deit_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst, cfg_start, cfg_abort, dma_ack, core_done, out_done;
    logic [7:0]  cfg_n_tiles, cfg_k_tiles;
    logic        dma_in_req, dma_wt_req, core_start, core_acc_mode, core_out_en;
    logic        seq_busy, seq_done, seq_err;
    logic [7:0]  dma_k_idx, dma_n_idx;
    logic [31:0] perf_cycles;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int n_done = 0;
    int busy_cnt = 0;
    int s0, d0, b0;

    logic [16:0] q_req[$];
    logic [2:0]  q_st[$];
    logic        p_in = 1'b0;
    logic        p_wt = 1'b0;

    deit_tile_sequencer dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
        .dma_in_req(dma_in_req), .dma_wt_req(dma_wt_req), .dma_ack(dma_ack),
        .dma_k_idx(dma_k_idx), .dma_n_idx(dma_n_idx),
        .core_start(core_start), .core_acc_mode(core_acc_mode), .core_out_en(core_out_en),
        .core_done(core_done), .out_done(out_done),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int n, input int k);
        for (int nn = 0; nn < n; nn++)
            for (int kk = 0; kk < k; kk++) begin
                q_req.push_back({1'b0, 8'(kk), 8'(nn)});
                q_req.push_back({1'b1, 8'(kk), 8'(nn)});
                q_st.push_back({1'b0, kk != 0, kk == k - 1});
            end
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        logic [2:0]  s;
        if (dma_in_req && !p_in) begin
            e = 17'h1FFFF;
            if (q_req.size() > 0) e = q_req.pop_front();
            chk("in_req_order", {1'b0, dma_k_idx, dma_n_idx}, e);
        end
        if (dma_wt_req && !p_wt) begin
            e = 17'h1FFFF;
            if (q_req.size() > 0) e = q_req.pop_front();
            chk("wt_req_order", {1'b1, dma_k_idx, dma_n_idx}, e);
        end
        if (core_start) begin
            s = 3'b100;
            if (q_st.size() > 0) s = q_st.pop_front();
            chk("start_mode", {1'b0, core_acc_mode, core_out_en}, s);
            n_starts <= n_starts + 1;
        end
        if (seq_done) n_done <= n_done + 1;
        if (seq_busy) busy_cnt <= busy_cnt + 1;
        p_in <= dma_in_req;
        p_wt <= dma_wt_req;
    end

    task automatic wait_high(input int sel, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((sel == 0 && dma_in_req) || (sel == 1 && dma_wt_req) || (sel == 2 && seq_done)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse(input int sel);
        if (sel == 0) dma_ack = 1'b1;
        if (sel == 1) core_done = 1'b1;
        if (sel == 2) out_done = 1'b1;
        @(negedge clk);
        dma_ack = 1'b0;
        core_done = 1'b0;
        out_done = 1'b0;
    endtask

    task automatic start(input int n, input int k);
        cfg_n_tiles = 8'(n);
        cfg_k_tiles = 8'(k);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic run(input int n, input int k, input int d);
        for (int nn = 0; nn < n; nn++)
            for (int kk = 0; kk < k; kk++) begin
                wait_high(0, "wait_in_req");
                repeat (d) @(negedge clk);
                if (d > 0) chk("in_req_held", 32'(dma_in_req), 32'd1);
                pulse(0);
                wait_high(1, "wait_wt_req");
                repeat (d) @(negedge clk);
                if (d > 0) chk("wt_req_held", 32'(dma_wt_req), 32'd1);
                pulse(0);
                repeat (d) @(negedge clk);
                pulse(1);
                if (kk == k - 1) begin
                    repeat (d) @(negedge clk);
                    pulse(2);
                end
            end
        wait_high(2, "wait_seq_done");
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        dma_ack = 1'b0;
        core_done = 1'b0;
        out_done = 1'b0;
        cfg_n_tiles = 8'd2;
        cfg_k_tiles = 8'd2;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {dma_in_req, dma_wt_req, core_start, core_acc_mode, core_out_en,
                              seq_busy, seq_done, seq_err, dma_k_idx, dma_n_idx}, 32'd0);
        chk("reset_perf", perf_cycles, 32'd0);
        rst = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(seq_busy), 32'd0);

        // N=2, K=2, immediate acks
        #1; s0 = n_starts; d0 = n_done;
        @(negedge clk);
        push_run(2, 2);
        start(2, 2);
        run(2, 2, 0);
        chk("t1_core_starts", 32'(n_starts - s0), 32'd4);
        chk("t1_seq_done", 32'(n_done - d0), 32'd1);
        chk("t1_seq_err", 32'(seq_err), 32'd0);
        chk("t1_queues_empty", 32'(q_req.size() + q_st.size()), 32'd0);
        chk("t1_idle", {seq_busy, dma_k_idx, dma_n_idx}, 32'd0);

        // N=1, K=3, acks delayed 10 cycles
        s0 = n_starts; d0 = n_done;
        @(negedge clk);
        push_run(1, 3);
        start(1, 3);
        run(1, 3, 10);
        chk("t2_core_starts", 32'(n_starts - s0), 32'd3);
        chk("t2_seq_done", 32'(n_done - d0), 32'd1);
        chk("t2_seq_err", 32'(seq_err), 32'd0);

        // zero reduction count
        s0 = n_starts;
        @(negedge clk);
        start(3, 0);
        chk("t3_done_fast", 32'(seq_done), 32'd1);
        chk("t3_seq_err", 32'(seq_err), 32'd1);
        chk("t3_no_req", {dma_in_req, dma_wt_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("t3_back_idle", 32'(seq_busy), 32'd0);
        chk("t3_no_start", 32'(n_starts - s0), 32'd0);

        // core_done before weight ack
        d0 = n_done;
        @(negedge clk);
        push_run(1, 2);
        start(1, 2);
        wait_high(0, "t4_wait_in");
        pulse(0);
        wait_high(1, "t4_wait_wt");
        pulse(1);
        chk("t4_seq_err", 32'(seq_err), 32'd1);
        chk("t4_wt_dropped", 32'(dma_wt_req), 32'd0);
        chk("t4_next_k", {dma_in_req, dma_k_idx}, {23'd0, 1'b1, 8'd1});
        pulse(0);
        wait_high(1, "t4_wait_wt1");
        pulse(0);
        pulse(1);
        pulse(2);
        wait_high(2, "t4_wait_done");
        @(negedge clk);
        #1;
        chk("t4_seq_done", 32'(n_done - d0), 32'd1);
        chk("t4_err_sticky", 32'(seq_err), 32'd1);

        // abort in DRAIN then a clean rerun
        d0 = n_done;
        @(negedge clk);
        q_req.push_back({1'b0, 8'd0, 8'd0});
        q_req.push_back({1'b1, 8'd0, 8'd0});
        q_st.push_back(3'b001);
        start(1, 1);
        wait_high(0, "t5_wait_in");
        pulse(0);
        wait_high(1, "t5_wait_wt");
        pulse(0);
        pulse(1);
        chk("t5_in_drain", {seq_busy, dma_in_req, dma_wt_req}, 32'd4);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("t5_abort_outputs", {dma_in_req, dma_wt_req, core_start, core_acc_mode, core_out_en,
                                 seq_busy, seq_done, seq_err, dma_k_idx, dma_n_idx}, 32'd0);
        #1;
        chk("t5_no_seq_done", 32'(n_done - d0), 32'd0);
        @(negedge clk);
        push_run(1, 1);
        start(1, 1);
        run(1, 1, 0);
        chk("t5_rerun_done", 32'(n_done - d0), 32'd1);
        chk("t5_rerun_err", 32'(seq_err), 32'd0);

        // busy-cycle counter, N=1, K=1, every handshake after 5 cycles
        b0 = busy_cnt;
        @(negedge clk);
        push_run(1, 1);
        start(1, 1);
        run(1, 1, 5);
`ifdef TILE_SEQ_PERF_CNT_EN
        chk("t6_perf_vs_busy", perf_cycles, 32'(busy_cnt - b0));
        chk("t6_perf_abs", perf_cycles, 32'd25);
`else
        chk("t6_busy_cycles", 32'(busy_cnt - b0), 32'd25);
        chk("t6_perf_tied", perf_cycles, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
